// File: rtl/spi_frame_master.sv
// spi_frame_master: parametrised SPI master with framing chip select,
// full-duplex receive, valid/ready word input and an incrementing-counter
// pattern generator used when no host word is offered.
module spi_frame_master #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DIV       = 2,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              gen_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(DIV - 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   gen_q, gen_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                tx_ready_q, tx_ready_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                rx_valid_q, rx_valid_d;

    logic                tick;
    logic [EDGE_W-1:0]   edge_n;
    logic [DATA_W-1:0]   start_word;

    // Bit that leaves the shift register next, in the configured order.
    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction

    // Drop the bit just sent.
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction

    // Insert a received bit so the first bit ends at bit 0 (LSB first) or MSB.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
        return LSB_FIRST ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        gen_d      = gen_q;
        rx_data_d  = rx_data_q;
        tx_ready_d = tx_ready_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        tick       = (div_q == DIV_MAX);
        edge_n     = edge_q + 1'b1;
        start_word = tx_valid ? tx_data : gen_q;

        case (state_q)
            S_IDLE: begin
                tx_ready_d = 1'b1;
                if (tx_ready_q && (tx_valid || gen_en)) begin
                    if (!tx_valid) begin
                        gen_d = gen_q + 1'b1;
                    end
                    tx_ready_d = 1'b0;
                    cs_n_d     = 1'b0;
                    div_d      = '0;
                    edge_d     = '0;
                    rx_sh_d    = '0;
                    state_d    = S_LEAD;
                    if (!CPHA) begin
                        mosi_d  = head_bit(start_word);
                        tx_sh_d = shift_out(start_word);
                    end else begin
                        tx_sh_d = start_word;
                    end
                end
            end

            S_LEAD, S_SHIFT: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    // The LEAD tick already performs toggle 1, so toggle k
                    // lands DIV cycles apart starting one DIV after the start.
                    if (state_q == S_LEAD) begin
                        edge_n = EDGE_W'(1);
                    end
                    edge_d = edge_n;
                    sclk_d = ~sclk_q;
                    if (edge_n[0] != CPHA) begin
                        rx_sh_d = shift_in(rx_sh_q, miso);
                    end
                    if ((CPHA && edge_n[0]) || (!CPHA && !edge_n[0] && edge_n != LAST_EDGE)) begin
                        mosi_d  = head_bit(tx_sh_q);
                        tx_sh_d = shift_out(tx_sh_q);
                    end
                    state_d = (edge_n == LAST_EDGE) ? S_TRAIL : S_SHIFT;
                end
            end

            S_TRAIL: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    state_d    = S_GAP;
                end
            end

            S_GAP: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    tx_ready_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            gen_q      <= DATA_W'(1);
            rx_data_q  <= '0;
            tx_ready_q <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            gen_q      <= gen_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule
